// File: rtl/game_pkg.sv
// Shared game definitions: mode codes, turn FSM states and player limits.
// The per-player position counters import the same mode constants.
package game_pkg;

    localparam logic [2:0] MODE_SETUP  = 3'b010;
    localparam logic [2:0] MODE_PLAY   = 3'b011;
    localparam int         MAX_PLAYERS = 4;
    localparam logic [4:0] STREAK_MAX  = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FLIP = 3'd1,
        ST_JUDGE     = 3'd2,
        ST_STEP      = 3'd3,
        ST_GAP       = 3'd4
    } turn_state_e;

    // Effective player count: anything at or below 2 plays as 2, anything at or above 4 plays as 4.
    function automatic logic [2:0] clamp_players(input logic [2:0] n);
        if (n <= 3'd2) begin
            return 3'd2;
        end else if (n >= 3'd4) begin
            return 3'd4;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/player_rotator.sv
// Next-player index: advances the active player and wraps modulo the clamped player count.
// An index already at or beyond the player count (count lowered mid-game) wraps straight to 0.
module player_rotator
    import game_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic [2:0] n_i,
    output logic [1:0] next_o
);

    logic [2:0] nEff;
    logic [2:0] incr;

    // Compare the incremented index against the clamped count and wrap to 0 when it runs off the end.
    always_comb begin
        nEff   = clamp_players(n_i);
        incr   = {1'b0, cur_i} + 3'd1;
        next_o = (incr >= nEff) ? 2'd0 : incr[1:0];
    end

endmodule

// File: rtl/turn_step_ctrl.sv
// Turn/step controller: judges each card flip against the tile ahead of the active player.
// A match sends a one-cycle step strobe to that player's position counter; a miss passes the turn.
module turn_step_ctrl
    import game_pkg::*;
#(
    parameter int STEP_GAP = 2,
    parameter int CARD_W   = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             M,
    input  logic [2:0]             N,
    input  logic                   flip_valid,
    input  logic [CARD_W-1:0]      flip_card,
    input  logic [CARD_W-1:0]      tile_ahead,
    output logic                   D,
    output logic [MAX_PLAYERS-1:0] p_da,
    output logic [1:0]             cur_player,
    output logic                   turn_over,
    output logic [4:0]             streak
);

    localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);
    localparam turn_state_e AFTER_STEP = (STEP_GAP == 0) ? ST_WAIT_FLIP : ST_GAP;

    turn_state_e       state_q;
    turn_state_e       state_d;
    logic [CARD_W-1:0] flipCard_q;
    logic [CARD_W-1:0] tileAhead_q;
    logic [1:0]        curPlayer_q;
    logic [4:0]        streak_q;
    logic [GAP_W-1:0]  gap_q;
    logic [1:0]        nextPlayer;
    logic              modeSetup;
    logic              modePlay;
    logic              isMatch;

    assign modeSetup = (M == MODE_SETUP);
    assign modePlay  = (M == MODE_PLAY);
    assign isMatch   = (flipCard_q == tileAhead_q);

    player_rotator uRotator (
        .cur_i  (curPlayer_q),
        .n_i    (N),
        .next_o (nextPlayer)
    );

    // State register; reset and SETUP both return the game to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: SETUP wins, HOLD freezes (a pending step is consumed silently), PLAY runs the turn.
    always_comb begin
        state_d = state_q;
        if (modeSetup) begin
            state_d = ST_IDLE;
        end else if (!modePlay) begin
            if (state_q == ST_STEP) begin
                state_d = AFTER_STEP;
            end
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_FLIP;
                ST_WAIT_FLIP: if (flip_valid) state_d = ST_JUDGE;
                ST_JUDGE:     state_d = isMatch ? ST_STEP : ST_WAIT_FLIP;
                ST_STEP:      state_d = AFTER_STEP;
                ST_GAP:       if (gap_q == GAP_LAST) state_d = ST_WAIT_FLIP;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Turn bookkeeping: flip latch, active player, match streak and post-step settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            flipCard_q  <= '0;
            tileAhead_q <= '0;
            curPlayer_q <= 2'd0;
            streak_q    <= 5'd0;
            gap_q       <= '0;
        end else if (modeSetup) begin
            curPlayer_q <= 2'd0;
            streak_q    <= 5'd0;
            gap_q       <= '0;
        end else begin
            if (modePlay && state_q == ST_WAIT_FLIP && flip_valid) begin
                flipCard_q  <= flip_card;
                tileAhead_q <= tile_ahead;
            end
            if (modePlay && state_q == ST_JUDGE) begin
                if (isMatch) begin
                    streak_q <= (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 5'd1;
                end else begin
                    streak_q    <= 5'd0;
                    curPlayer_q <= nextPlayer;
                end
            end
            if (state_q == ST_GAP) begin
                if (modePlay) begin
                    gap_q <= gap_q + GAP_W'(1);
                end
            end else begin
                gap_q <= '0;
            end
        end
    end

    // Outputs: strobe and turn pulse only while actually playing, so HOLD and SETUP silence them.
    always_comb begin
        D          = 1'b0;
        p_da       = '0;
        turn_over  = 1'b0;
        cur_player = curPlayer_q;
        streak     = streak_q;
        if (modePlay) begin
            if (state_q == ST_STEP) begin
                D    = 1'b1;
                p_da = MAX_PLAYERS'(1) << curPlayer_q;
            end
            if (state_q == ST_JUDGE && !isMatch) begin
                turn_over = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turn_step_ctrl.sv
// Testbench for turn_step_ctrl: vector table, hand-written corner sequences and a randomized
// run against a timeline model of flips, judgements and strobes.
module tb_turn_step_ctrl;

   localparam int STEP_GAP = 2;
   localparam logic [2:0] PLAY  = 3'b011;
   localparam logic [2:0] SETUP = 3'b010;
   localparam logic [2:0] HOLD  = 3'b000;

   logic       clk;
   logic       rst;
   logic [2:0] mIn;
   logic [2:0] nIn;
   logic       flipValid;
   logic [3:0] flipCard;
   logic [3:0] tileAhead;
   logic       dOut;
   logic [3:0] pDa;
   logic [1:0] curPlayer;
   logic       turnOver;
   logic [4:0] streakOut;

   int compared = 0;
   int mismatched = 0;
   logic [2:0] nDrive = 3'd3;

   typedef struct {
      logic       r;
      logic [2:0] m;
      logic [2:0] n;
      logic       fv;
      logic [3:0] card;
      logic [3:0] tile;
      logic       expD;
      logic [3:0] expP;
      logic [1:0] expCur;
      logic       expTurn;
      logic [4:0] expStreak;
   } vec_t;

   vec_t vecs[$];

   turn_step_ctrl #(.STEP_GAP(STEP_GAP), .CARD_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .M          (mIn),
      .N          (nIn),
      .flip_valid (flipValid),
      .flip_card  (flipCard),
      .tile_ahead (tileAhead),
      .D          (dOut),
      .p_da       (pDa),
      .cur_player (curPlayer),
      .turn_over  (turnOver),
      .streak     (streakOut)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the sequencing goes wrong.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic r, input logic [2:0] m, input logic [2:0] n,
                                input logic fv, input logic [3:0] c, input logic [3:0] t);
      rst       = r;
      mIn       = m;
      nIn       = n;
      flipValid = fv;
      flipCard  = c;
      tileAhead = t;
   endtask

   task automatic checkOutput(input string name, input logic expD, input logic [3:0] expP,
                              input logic [1:0] expCur, input logic expTurn, input logic [4:0] expStreak);
      compared++;
      if ({dOut, pDa, curPlayer, turnOver, streakOut} !== {expD, expP, expCur, expTurn, expStreak}) begin
         mismatched++;
         $display("[TB] FAIL %s @%0t: got D=%b p_da=%b cur=%0d turn=%b streak=%0d, want D=%b p_da=%b cur=%0d turn=%b streak=%0d",
                  name, $time, dOut, pDa, curPlayer, turnOver, streakOut,
                  expD, expP, expCur, expTurn, expStreak);
      end
   endtask

   task automatic checkStrobe(input string name, input logic expD, input logic [3:0] expP, input logic expTurn);
      compared++;
      if ({dOut, pDa, turnOver} !== {expD, expP, expTurn}) begin
         mismatched++;
         $display("[TB] FAIL %s @%0t: got D=%b p_da=%b turn=%b, want D=%b p_da=%b turn=%b",
                  name, $time, dOut, pDa, turnOver, expD, expP, expTurn);
      end
   endtask

   task automatic resetDut();
      applyStimulus(1'b1, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      tick();
   endtask

   // Matching flip from WAIT_FLIP; checks the strobe two cycles later and returns in WAIT_FLIP.
   task automatic flipMatch(input logic [1:0] expCur, input logic [4:0] expStreak);
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, PLAY, nDrive, 1'b1, c, c);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      #1 checkOutput("match_step", 1'b1, 4'b0001 << expCur, expCur, 1'b0, expStreak);
      for (int k = 0; k < STEP_GAP + 1; k++) tick();
   endtask

   // Missing flip from WAIT_FLIP; checks the turn pulse and the rotated player afterwards.
   task automatic flipMiss(input logic [1:0] expCur, input logic [4:0] expStreak, input logic [1:0] nextCur);
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, PLAY, nDrive, 1'b1, c, c ^ 4'd1);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      #1 checkOutput("miss_judge", 1'b0, 4'd0, expCur, 1'b1, expStreak);
      tick();
      #1 checkOutput("miss_after", 1'b0, 4'd0, nextCur, 1'b0, 5'd0);
   endtask

   function automatic void addVec(input logic r, input logic [2:0] m, input logic fv,
                                  input logic [3:0] c, input logic [3:0] t, input logic expD,
                                  input logic [3:0] expP, input logic [1:0] expCur,
                                  input logic expTurn, input logic [4:0] expStreak);
      vec_t v;
      v.r = r; v.m = m; v.n = 3'd3; v.fv = fv; v.card = c; v.tile = t;
      v.expD = expD; v.expP = expP; v.expCur = expCur; v.expTurn = expTurn; v.expStreak = expStreak;
      vecs.push_back(v);
   endfunction

   function automatic int neffOf(input int n);
      if (n <= 2) return 2;
      if (n >= 4) return 4;
      return n;
   endfunction

   // Main sequence: vector table, directed corner cases, then randomized run.
   initial begin
      int mPlayer;
      int mStreak;
      int judgeCyc;
      int stepCyc;
      int acceptFrom;
      bit judgeMatch;
      logic       rfv;
      logic [2:0] rn;
      logic [3:0] rc;
      logic [3:0] rt;
      logic       eD;
      logic       eTurn;

      // ---- vector table: first match, dropped flips in GAP, misses, SETUP in GAP, HOLD in GAP ----
      addVec(1, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  1, 5, 5,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  1, 4'b0001, 0, 0, 1);
      addVec(0, PLAY,  1, 5, 5,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  1, 5, 5,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  1, 3, 3,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  1, 4'b0001, 0, 0, 2);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 2);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 2);
      addVec(0, PLAY,  1, 1, 2,  0, 4'b0000, 0, 0, 2);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 1, 2);
      addVec(0, PLAY,  1, 1, 2,  0, 4'b0000, 1, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 1, 1, 0);
      addVec(0, PLAY,  1, 1, 2,  0, 4'b0000, 2, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 2, 1, 0);
      addVec(0, PLAY,  1, 4, 6,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 1, 0);
      addVec(0, PLAY,  1, 4, 6,  0, 4'b0000, 1, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 1, 1, 0);
      addVec(0, PLAY,  1, 7, 7,  0, 4'b0000, 2, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 2, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  1, 4'b0100, 2, 0, 1);
      addVec(0, SETUP, 0, 0, 0,  0, 4'b0000, 2, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  1, 9, 9,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 0);
      addVec(0, PLAY,  0, 0, 0,  1, 4'b0001, 0, 0, 1);
      addVec(0, HOLD,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, HOLD,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  1, 2, 2,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  1, 2, 2,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  0, 4'b0000, 0, 0, 1);
      addVec(0, PLAY,  0, 0, 0,  1, 4'b0001, 0, 0, 2);

      nDrive = 3'd3;
      resetDut();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].r, vecs[i].m, vecs[i].n, vecs[i].fv, vecs[i].card, vecs[i].tile);
         #1 checkOutput($sformatf("vec%0d", i), vecs[i].expD, vecs[i].expP, vecs[i].expCur,
                        vecs[i].expTurn, vecs[i].expStreak);
         tick();
      end

      // ---- streak saturation over 33 matches, then a miss clears it ----
      nDrive = 3'd3;
      resetDut();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      for (int i = 0; i < 33; i++) flipMatch(2'd0, 5'((i + 1 > 31) ? 31 : i + 1));
      flipMiss(2'd0, 5'd31, 2'd1);

      // ---- player count lowered mid-game, and an oversized count behaving as 4 ----
      nDrive = 3'd4;
      resetDut();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      flipMiss(2'd0, 5'd0, 2'd1);
      flipMiss(2'd1, 5'd0, 2'd2);
      flipMiss(2'd2, 5'd0, 2'd3);
      nDrive = 3'd2;
      flipMiss(2'd3, 5'd0, 2'd0);
      nDrive = 3'd7;
      flipMiss(2'd0, 5'd0, 2'd1);
      flipMiss(2'd1, 5'd0, 2'd2);
      flipMiss(2'd2, 5'd0, 2'd3);
      flipMiss(2'd3, 5'd0, 2'd0);

      // ---- HOLD while in STEP suppresses the strobe and resumes in GAP ----
      nDrive = 3'd3;
      resetDut();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b1, 4'd6, 4'd6);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      applyStimulus(1'b0, HOLD, nDrive, 1'b0, 4'd0, 4'd0);
      #1 checkStrobe("hold_step", 1'b0, 4'd0, 1'b0);
      tick();
      #1 checkStrobe("hold_gap", 1'b0, 4'd0, 1'b0);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      #1 checkStrobe("resume_gap0", 1'b0, 4'd0, 1'b0);
      tick();
      #1 checkStrobe("resume_gap1", 1'b0, 4'd0, 1'b0);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b1, 4'd8, 4'd8);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      #1 checkStrobe("after_hold_step", 1'b1, 4'b0001, 1'b0);
      tick();

      // ---- reset during JUDGE of a match cancels the coming strobe ----
      nDrive = 3'd3;
      resetDut();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      flipMiss(2'd0, 5'd0, 2'd1);
      applyStimulus(1'b0, PLAY, nDrive, 1'b1, 4'd2, 4'd2);
      tick();
      applyStimulus(1'b1, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      tick();
      applyStimulus(1'b0, PLAY, nDrive, 1'b0, 4'd0, 4'd0);
      #1 checkOutput("rst_cancel", 1'b0, 4'd0, 2'd0, 1'b0, 5'd0);
      tick();
      #1 checkOutput("rst_no_strobe", 1'b0, 4'd0, 2'd0, 1'b0, 5'd0);
      tick();

      // ---- randomized run against a flip/judge/strobe timeline model ----
      nDrive = 3'd3;
      resetDut();
      mPlayer    = 0;
      mStreak    = 0;
      judgeCyc   = -1;
      stepCyc    = -1;
      acceptFrom = 1;
      judgeMatch = 1'b0;
      rn         = 3'd3;
      for (int c = 0; c < 800; c++) begin
         rfv = ($urandom_range(0, 1) == 1);
         rc  = 4'($urandom_range(0, 3));
         rt  = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) rn = 3'($urandom_range(0, 7));
         applyStimulus(1'b0, PLAY, rn, rfv, rc, rt);
         eD    = (stepCyc == c);
         eTurn = (judgeCyc == c) && !judgeMatch;
         #1 checkOutput("random", eD, eD ? 4'(1 << mPlayer) : 4'd0, 2'(mPlayer), eTurn, 5'(mStreak));
         if (judgeCyc == c) begin
            if (judgeMatch) begin
               mStreak    = (mStreak >= 31) ? 31 : mStreak + 1;
               stepCyc    = c + 1;
               acceptFrom = c + 2 + STEP_GAP;
            end else begin
               mPlayer    = (mPlayer + 1 >= neffOf(int'(rn))) ? 0 : mPlayer + 1;
               mStreak    = 0;
               acceptFrom = c + 1;
            end
            judgeCyc = -1;
         end
         if (rfv && c >= acceptFrom) begin
            judgeCyc   = c + 1;
            judgeMatch = (rc == rt);
            acceptFrom = 1 << 30;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
